// File: rtl/div_pkg.sv
// Shared definitions for the sequential 16x8 restoring divider: default widths
// and the controller state encoding shown on the board display.
package div_pkg;

  localparam int DEF_WIDTH_N = 16;
  localparam int DEF_WIDTH_D = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_DONE = 3'd2,
    ST_ERR  = 3'd3
  } state_t;

endpackage

// File: rtl/divider16x8_seq_if.sv
// Request/result bundle of the divider. The master issues start with operands;
// the slave (divider) returns status, result and display signals.
interface divider16x8_seq_if #(
  parameter int WIDTH_N = 16,
  parameter int WIDTH_D = 8
);
  // Handshake: start is a level request sampled on each rising clk edge while the
  // divider is in IDLE, DONE or ERR; dividend/divisor must be valid in that same
  // cycle. done_flag high means quotient/remainder are valid and stay stable until
  // the next accepted start. busy high means start is ignored.
  logic               start;
  logic [WIDTH_N-1:0] dividend;
  logic [WIDTH_D-1:0] divisor;
  logic               busy;
  logic               done_flag;
  logic               div_by_zero;
  logic [WIDTH_N-1:0] quotient;
  logic [WIDTH_D-1:0] remainder;
  logic [2:0]         state_out;
  logic [6:0]         seven_segment;

  modport master (
    output start, dividend, divisor,
    input  busy, done_flag, div_by_zero, quotient, remainder, state_out, seven_segment
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done_flag, div_by_zero, quotient, remainder, state_out, seven_segment
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH_N = 16,
  parameter int WIDTH_D = 8
) (
  input  logic [WIDTH_D:0]   i_r,
  input  logic [WIDTH_N-1:0] i_q,
  input  logic [WIDTH_D-1:0] i_d,
  output logic [WIDTH_D:0]   o_r,
  output logic [WIDTH_N-1:0] o_q
);
  logic [WIDTH_D:0] w_rs;
  logic [WIDTH_D:0] w_sub;
  logic             w_ge;
  logic             w_unused_r_msb;

  // The restored remainder is always below the divisor, so its top bit is zero.
  assign w_unused_r_msb = i_r[WIDTH_D];

  assign w_rs  = {i_r[WIDTH_D-1:0], i_q[WIDTH_N-1]};
  assign w_ge  = (w_rs >= {1'b0, i_d});
  assign w_sub = w_rs - {1'b0, i_d};
  assign o_r   = w_ge ? w_sub : w_rs;
  assign o_q   = {i_q[WIDTH_N-2:0], w_ge};
endmodule

// File: rtl/seg.sv
// Seven-segment decoder (segments gfedcba, active high) for a 3-bit value.
module seg (
  input  logic [2:0] i_val,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = 7'h00;
    case (i_val)
      3'd0:    o_seg = 7'h3F;
      3'd1:    o_seg = 7'h06;
      3'd2:    o_seg = 7'h5B;
      3'd3:    o_seg = 7'h4F;
      3'd4:    o_seg = 7'h66;
      3'd5:    o_seg = 7'h6D;
      3'd6:    o_seg = 7'h7D;
      default: o_seg = 7'h07;
    endcase
  end
endmodule

// File: rtl/divider16x8_seq.sv
// Sequential unsigned 16/8 restoring divider, one quotient bit per clock,
// with a start/done controller whose state is exported for the display.
module divider16x8_seq
  import div_pkg::*;
#(
  parameter int WIDTH_N = DEF_WIDTH_N,
  parameter int WIDTH_D = DEF_WIDTH_D
) (
  input logic             clk,
  input logic             reset_n,
  divider16x8_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH_N) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH_N - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH_N-1:0] r_q;
  logic [WIDTH_N-1:0] r_quotient;
  logic [WIDTH_N-1:0] w_q_next;
  logic [WIDTH_D:0]   r_r;
  logic [WIDTH_D:0]   w_r_next;
  logic [WIDTH_D-1:0] r_d;
  logic [WIDTH_D-1:0] r_remainder;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_zero_div;
  logic               w_last;
  logic               w_busy;
  logic               w_done;
  logic               w_dbz;
  logic [2:0]         w_state_out;
  logic [6:0]         w_seg;

  assign w_zero_div = (bus.divisor == '0);
  assign w_last     = (r_cnt == LAST_STEP);

  div_step #(.WIDTH_N(WIDTH_N), .WIDTH_D(WIDTH_D)) u_step (
    .i_r (r_r),
    .i_q (r_q),
    .i_d (r_d),
    .o_r (w_r_next),
    .o_q (w_q_next)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Every non-CALC state accepts start, which also recovers unused encodings.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_CALC: if (w_last) w_next_state = ST_DONE;
      default: if (bus.start) w_next_state = w_zero_div ? ST_ERR : ST_CALC;
    endcase
  end

  always_comb begin
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_dbz       = 1'b0;
    w_state_out = r_state;
    case (r_state)
      ST_CALC: w_busy = 1'b1;
      ST_DONE: w_done = 1'b1;
      ST_ERR: begin
        w_done = 1'b1;
        w_dbz  = 1'b1;
      end
      default: ;
    endcase
  end

  // Result registers change only on entry to DONE or ERR; the working
  // registers are free to churn underneath while CALC runs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_q         <= '0;
      r_r         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else if (r_state == ST_CALC) begin
      r_q   <= w_q_next;
      r_r   <= w_r_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_quotient  <= w_q_next;
        r_remainder <= w_r_next[WIDTH_D-1:0];
      end
    end else if (bus.start) begin
      if (w_zero_div) begin
        r_quotient  <= '1;
        r_remainder <= '0;
      end else begin
        r_q   <= bus.dividend;
        r_r   <= '0;
        r_d   <= bus.divisor;
        r_cnt <= '0;
      end
    end
  end

  seg u_seg (
    .i_val (w_state_out),
    .o_seg (w_seg)
  );

  assign bus.busy          = w_busy;
  assign bus.done_flag     = w_done;
  assign bus.div_by_zero   = w_dbz;
  assign bus.quotient      = r_quotient;
  assign bus.remainder     = r_remainder;
  assign bus.state_out     = w_state_out;
  assign bus.seven_segment = w_seg;
endmodule

// File: tb/tb_divider16x8_seq.sv
// Directed bench for divider16x8_seq: reset, normal and extreme divisions,
// divide by zero, reset mid-operation and start handshake corner cases.
module tb_divider16x8_seq;
  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;
  logic [23:0] exp_q[$];

  divider16x8_seq_if bus ();

  divider16x8_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (cycles) @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
  endtask

  // Pulses start for one edge; returns at the negedge right after the accepting edge.
  task automatic start_op(input logic [15:0] dvd, input logic [7:0] dvs,
                          input logic [15:0] eq, input logic [7:0] er);
    @(negedge clk);
    bus.dividend = dvd;
    bus.divisor  = dvs;
    bus.start    = 1'b1;
    exp_q.push_back({eq, er});
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cycles;
    cycles = 0;
    while (!bus.done_flag && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_latency"}, cycles, 16);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_result(input string tag);
    logic [23:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_done"}, bus.done_flag, 1);
      check({tag, "_quot"}, bus.quotient, e[23:8]);
      check({tag, "_rem"},  bus.remainder, e[7:0]);
    end
  endtask

  task automatic check_idle_cleared(input string tag);
    check({tag, "_quot"},  bus.quotient, 0);
    check({tag, "_rem"},   bus.remainder, 0);
    check({tag, "_busy"},  bus.busy, 0);
    check({tag, "_done"},  bus.done_flag, 0);
    check({tag, "_dbz"},   bus.div_by_zero, 0);
    check({tag, "_state"}, bus.state_out, 0);
    check({tag, "_seg"},   bus.seven_segment, 7'h3F);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_vec        = 0;
    n_err        = 0;
    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // 1: reset
    do_reset(2);
    check_idle_cleared("reset");

    // 2: normal 1000/7
    start_op(16'd1000, 8'd7, 16'd142, 8'd6);
    check("norm_busy",  bus.busy, 1);
    check("norm_state", bus.state_out, 1);
    check("norm_seg",   bus.seven_segment, 7'h06);
    wait_done("norm");
    check_result("norm");
    check("norm_dstate", bus.state_out, 2);
    check("norm_dseg",   bus.seven_segment, 7'h5B);

    // 3: extremes; previous result held during CALC
    start_op(16'hFFFF, 8'd1, 16'hFFFF, 8'd0);
    check("ext1_drop_done", bus.done_flag, 0);
    repeat (5) @(negedge clk);
    check("ext1_hold_quot", bus.quotient, 142);
    check("ext1_hold_rem",  bus.remainder, 6);
    repeat (11) @(negedge clk);
    check("ext1_latency", bus.done_flag, 1);
    check_result("ext1");
    start_op(16'd5, 8'd200, 16'd0, 8'd5);
    wait_done("ext2");
    check_result("ext2");

    // 4: divide by zero, ERR on the accepting edge, then held
    start_op(16'd1234, 8'd0, 16'hFFFF, 8'd0);
    check("dbz_state", bus.state_out, 3);
    check("dbz_flag",  bus.div_by_zero, 1);
    check("dbz_busy",  bus.busy, 0);
    check("dbz_seg",   bus.seven_segment, 7'h4F);
    check_result("dbz");
    repeat (3) @(negedge clk);
    check("dbz_hold_state", bus.state_out, 3);
    check("dbz_hold_quot",  bus.quotient, 16'hFFFF);

    // 5: reset mid-op with start held high (reset wins), then restart
    start_op(16'd40000, 8'd3, 16'd13333, 8'd1);
    check("rst_dbz_drop", bus.div_by_zero, 0);
    check("rst_busy",     bus.busy, 1);
    repeat (7) @(negedge clk);
    reset_n   = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    check_idle_cleared("rst_mid");
    @(negedge clk);
    check("rst_prio_state", bus.state_out, 0);
    bus.start = 1'b0;
    reset_n   = 1'b1;
    exp_q.delete();
    start_op(16'd40000, 8'd3, 16'd13333, 8'd1);
    wait_done("restart");
    check_result("restart");

    // 6: start held through CALC gives a single operation
    @(negedge clk);
    bus.dividend = 16'd600;
    bus.divisor  = 8'd25;
    bus.start    = 1'b1;
    exp_q.push_back({16'd24, 8'd0});
    @(negedge clk);
    check("held_busy", bus.busy, 1);
    wait_done("held");
    bus.start = 1'b0;
    check_result("held");
    @(negedge clk);
    check("held_once_state", bus.state_out, 2);
    check("held_once_quot",  bus.quotient, 24);

    // back-to-back from DONE with 255/16
    start_op(16'd255, 8'd16, 16'd15, 8'd15);
    check("b2b_accept", bus.state_out, 1);
    check("b2b_hold_quot", bus.quotient, 24);
    wait_done("b2b");
    check_result("b2b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
